// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with req/gnt/rvalid memory port and output FIFO
module instr_fetch_unit #(
  parameter int XLEN = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [XLEN-1:0] PC,
  output logic            PC_ADV,
  input  logic            FLUSH,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [31:0]     IMEM_RDATA,
  output logic            INSTR_VALID,
  input  logic            INSTR_READY,
  output logic [31:0]     INSTR,
  output logic [XLEN-1:0] INSTR_PC,
  output logic            FETCH_MISALIGN
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic misalign_q, misalign_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [31:0] instr_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem_q [FIFO_DEPTH];
  logic push, pop, grant;
  // request is gated by reset so all outputs read 0 while RST_N is held low
  assign IMEM_REQ = RST_N && state_q == IDLE && !FLUSH && PC[1:0] == 2'b00 && !misalign_q
                    && count_q < (AW+1)'(FIFO_DEPTH);
  assign IMEM_ADDR = IMEM_REQ ? PC : '0;
  assign grant = IMEM_REQ && IMEM_GNT;
  assign PC_ADV = grant;
  assign FETCH_MISALIGN = misalign_q;
  assign INSTR_VALID = count_q != '0;
  assign INSTR = INSTR_VALID ? instr_mem_q[rd_ptr_q] : '0;
  assign INSTR_PC = INSTR_VALID ? pc_mem_q[rd_ptr_q] : '0;
  assign push = state_q == WAIT && IMEM_RVALID && !FLUSH;
  assign pop = INSTR_VALID && INSTR_READY;
  always_comb begin
    state_d = state_q;
    req_pc_d = grant ? PC : req_pc_q;
    unique case (state_q)
      IDLE:    state_d = grant ? WAIT : IDLE;
      WAIT:    state_d = IMEM_RVALID ? IDLE : (FLUSH ? DRAIN : WAIT);
      DRAIN:   state_d = IMEM_RVALID ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    misalign_d = FLUSH ? 1'b0 : (misalign_q || (state_q == IDLE && PC[1:0] != 2'b00));
    count_d = FLUSH ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d = FLUSH ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = FLUSH ? '0 : rd_ptr_q + AW'(pop);
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      req_pc_q <= '0;
      misalign_q <= 1'b0;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      req_pc_q <= req_pc_d;
      misalign_q <= misalign_d;
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST_N && push) begin
      instr_mem_q[wr_ptr_q] <= IMEM_RDATA;
      pc_mem_q[wr_ptr_q] <= req_pc_q;
    end
  end
endmodule
